centroid_div_sched: RTL and testbench

- Sequences a single shared 32/20 sequential divider to compute both centroid coordinates (x = m10/m00, y = m01/m00) for each video frame.
- Sits between the moment accumulators/white-pixel counter and the divider instance, replacing one of the two per-axis dividers.
- Snapshots the moments at end of frame and buffers one pending frame if the divider is still busy.
- Publishes both coordinates atomically, with clamping, empty-frame and timeout handling.

---
 rtl/centroid_div_sched.sv | 208 ++++++++++++++++++++
 tb/tb_centroid_div_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/centroid_div_sched.sv
// rtl/centroid_div_sched.sv - shared-divider scheduler for centroid x/y
// Snapshots frame moments, runs x then y through one divider, publishes both together.
module centroid_div_sched #(
   parameter int IMG_W   = 64,
   parameter int IMG_H   = 64,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        eof,
   input  logic [29:0] m10,
   input  logic [29:0] m01,
   input  logic [19:0] m00,
   output logic        div_start,
   output logic [31:0] div_dividend,
   output logic [19:0] div_divisor,
   input  logic [31:0] div_quotient,
   input  logic        div_qv,
   output logic [10:0] x,
   output logic [10:0] y,
   output logic        valid,
   output logic        no_obj,
   output logic        busy,
   output logic        overrun,
   output logic        timeout_err
);

   localparam int          CW      = $clog2(TIMEOUT + 1);
   localparam logic [10:0] X_CLAMP = 11'(IMG_W - 1);
   localparam logic [10:0] Y_CLAMP = 11'(IMG_H - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START_X, S_WAIT_X, S_START_Y, S_WAIT_Y, S_PUBLISH
   } state_t;

   state_t      state_q, state_d;
   logic [29:0] m10_snap_q, m10_snap_d, m01_snap_q, m01_snap_d;
   logic [19:0] m00_snap_q, m00_snap_d;
   logic        empty_q, empty_d;
   logic        pend_full_q, pend_full_d;
   logic [29:0] pend_m10_q, pend_m10_d, pend_m01_q, pend_m01_d;
   logic [19:0] pend_m00_q, pend_m00_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [10:0] x_tmp_q, x_tmp_d, y_tmp_q, y_tmp_d;
   logic [10:0] x_q, x_d, y_q, y_d;
   logic        valid_q, valid_d, no_obj_q, no_obj_d;
   logic        overrun_q, overrun_d, tout_q, tout_d;

   logic        take_eof, take_pend;
   logic [29:0] src_m10, src_m01;
   logic [19:0] src_m00;

   always_comb begin
      state_d     = state_q;
      m10_snap_d  = m10_snap_q;
      m01_snap_d  = m01_snap_q;
      m00_snap_d  = m00_snap_q;
      empty_d     = empty_q;
      pend_full_d = pend_full_q;
      pend_m10_d  = pend_m10_q;
      pend_m01_d  = pend_m01_q;
      pend_m00_d  = pend_m00_q;
      cnt_d       = '0;
      x_tmp_d     = x_tmp_q;
      y_tmp_d     = y_tmp_q;
      x_d         = x_q;
      y_d         = y_q;
      valid_d     = 1'b0;
      no_obj_d    = no_obj_q;
      overrun_d   = overrun_q;
      tout_d      = tout_q;
      take_eof    = 1'b0;
      take_pend   = 1'b0;
      src_m10     = m10;
      src_m01     = m01;
      src_m00     = m00;

      case (state_q)
         S_IDLE: begin
            if (pend_full_q)  take_pend = 1'b1;
            else if (eof)     take_eof  = 1'b1;
         end
         S_START_X: state_d = S_WAIT_X;
         S_WAIT_X: begin
            if (div_qv) begin
               x_tmp_d = (div_quotient > {21'd0, X_CLAMP}) ? X_CLAMP : div_quotient[10:0];
               state_d = S_START_Y;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               tout_d    = 1'b1;
               overrun_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_START_Y: state_d = S_WAIT_Y;
         S_WAIT_Y: begin
            if (div_qv) begin
               y_tmp_d = (div_quotient > {21'd0, Y_CLAMP}) ? Y_CLAMP : div_quotient[10:0];
               state_d = S_PUBLISH;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               tout_d    = 1'b1;
               overrun_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_PUBLISH: begin
            // Empty frames were already published on entry to this state.
            if (!empty_q) begin
               x_d      = x_tmp_q;
               y_d      = y_tmp_q;
               no_obj_d = 1'b0;
               valid_d  = 1'b1;
            end
            state_d = S_IDLE;
            if (pend_full_q)  take_pend = 1'b1;
            else if (eof)     take_eof  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (eof && !take_eof) begin
         if (pend_full_q && !take_pend) overrun_d = 1'b1;
         pend_full_d = 1'b1;
         pend_m10_d  = m10;
         pend_m01_d  = m01;
         pend_m00_d  = m00;
      end else if (take_pend) begin
         pend_full_d = 1'b0;
      end

      if (take_pend) begin
         src_m10 = pend_m10_q;
         src_m01 = pend_m01_q;
         src_m00 = pend_m00_q;
      end

      if (take_eof || take_pend) begin
         m10_snap_d = src_m10;
         m01_snap_d = src_m01;
         m00_snap_d = src_m00;
         empty_d    = (src_m00 == 20'd0);
         if (src_m00 == 20'd0) begin
            state_d  = S_PUBLISH;
            valid_d  = 1'b1;
            no_obj_d = 1'b1;
         end else begin
            state_d = S_START_X;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         m10_snap_q  <= '0;
         m01_snap_q  <= '0;
         m00_snap_q  <= '0;
         empty_q     <= 1'b0;
         pend_full_q <= 1'b0;
         pend_m10_q  <= '0;
         pend_m01_q  <= '0;
         pend_m00_q  <= '0;
         cnt_q       <= '0;
         x_tmp_q     <= '0;
         y_tmp_q     <= '0;
         x_q         <= '0;
         y_q         <= '0;
         valid_q     <= 1'b0;
         no_obj_q    <= 1'b0;
         overrun_q   <= 1'b0;
         tout_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         m10_snap_q  <= m10_snap_d;
         m01_snap_q  <= m01_snap_d;
         m00_snap_q  <= m00_snap_d;
         empty_q     <= empty_d;
         pend_full_q <= pend_full_d;
         pend_m10_q  <= pend_m10_d;
         pend_m01_q  <= pend_m01_d;
         pend_m00_q  <= pend_m00_d;
         cnt_q       <= cnt_d;
         x_tmp_q     <= x_tmp_d;
         y_tmp_q     <= y_tmp_d;
         x_q         <= x_d;
         y_q         <= y_d;
         valid_q     <= valid_d;
         no_obj_q    <= no_obj_d;
         overrun_q   <= overrun_d;
         tout_q      <= tout_d;
      end
   end

   assign div_start    = (state_q == S_START_X) || (state_q == S_START_Y);
   assign div_dividend = {2'b00, ((state_q == S_START_Y) || (state_q == S_WAIT_Y)) ? m01_snap_q : m10_snap_q};
   assign div_divisor  = m00_snap_q;
   assign x            = x_q;
   assign y            = y_q;
   assign valid        = valid_q;
   assign no_obj       = no_obj_q;
   assign busy         = (state_q != S_IDLE);
   assign overrun      = overrun_q;
   assign timeout_err  = tout_q;

endmodule

// File: tb/tb_centroid_div_sched.sv
// tb/tb_centroid_div_sched.sv - bench for centroid_div_sched
// Frame vectors with a 34-cycle divider model and a result scoreboard.
module tb_centroid_div_sched;
   localparam int IMG_W = 64, IMG_H = 64, TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        rst, eof;
   logic [29:0] m10, m01;
   logic [19:0] m00;
   logic        div_start, div_qv;
   logic [31:0] div_dividend, div_quotient;
   logic [19:0] div_divisor;
   logic [10:0] x, y;
   logic        valid, no_obj, busy, overrun, timeout_err;

   centroid_div_sched #(.IMG_W(IMG_W), .IMG_H(IMG_H), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .eof(eof), .m10(m10), .m01(m01), .m00(m00),
      .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_qv(div_qv),
      .x(x), .y(y), .valid(valid), .no_obj(no_obj), .busy(busy),
      .overrun(overrun), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0, checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct { logic [10:0] x; logic [10:0] y; logic no_obj; } res_t;
   res_t        sb_q[$];
   logic [31:0] dvd_q[$];
   logic [19:0] dvs_q[$];
   int          valid_cnt = 0, last_valid_cyc = 0, last_start_cyc = 0, consec_err = 0;
   logic        prev_start = 1'b0;

   // Output monitor: records divider starts and scores published results
   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         if (div_start) begin
            if (prev_start) consec_err++;
            dvd_q.push_back(div_dividend);
            dvs_q.push_back(div_divisor);
            last_start_cyc = cyc;
         end
         prev_start = div_start;
         if (valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got x=%0d y=%0d expected no valid", x, y);
            end else begin
               e = sb_q.pop_front();
               chk("pub_x", 32'(x), 32'(e.x));
               chk("pub_y", 32'(y), 32'(e.y));
               chk("pub_no_obj", 32'(no_obj), 32'(e.no_obj));
            end
         end
      end
   end

   // Divider model: quotient valid 34 cycles after the start cycle
   int          div_cnt = 0;
   logic        div_en = 1'b1;
   logic [31:0] force_q[$];
   logic [31:0] pend_quot = '0;
   initial begin
      div_qv = 1'b0;
      div_quotient = '0;
      forever begin
         @(negedge clk);
         div_qv = 1'b0;
         if (div_cnt > 0) begin
            div_cnt--;
            if (div_cnt == 0) begin
               div_qv = 1'b1;
               div_quotient = pend_quot;
            end
         end
         if (div_start && div_en) begin
            div_cnt = 34;
            if (force_q.size() > 0) pend_quot = force_q.pop_front();
            else pend_quot = div_dividend / {12'd0, div_divisor};
         end
      end
   end

   typedef struct {
      logic [29:0] m10; logic [29:0] m01; logic [19:0] m00;
      logic frc; logic [31:0] fqx; logic [31:0] fqy;
      logic [10:0] ex; logic [10:0] ey; logic eno; int elat;
   } vec_t;
   vec_t tbl[8];

   task automatic drive_eof(input logic [29:0] a10, input logic [29:0] a01, input logic [19:0] a00, output int t);
      @(negedge clk);
      m10 = a10; m01 = a01; m00 = a00; eof = 1'b1;
      t = cyc;
      @(negedge clk);
      eof = 1'b0;
   endtask

   task automatic wait_valids(input int target, input int budget);
      for (int k = 0; k < budget && valid_cnt < target; k++) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic run_frame(input vec_t v, input string tag);
      int t, w;
      dvd_q.delete();
      dvs_q.delete();
      if (v.frc) begin
         force_q.push_back(v.fqx);
         force_q.push_back(v.fqy);
      end
      sb_q.push_back('{v.ex, v.ey, v.eno});
      w = valid_cnt;
      drive_eof(v.m10, v.m01, v.m00, t);
      wait_valids(w + 1, 300);
      chk({tag, "_latency"}, 32'(last_valid_cyc - t), 32'(v.elat));
      repeat (3) @(negedge clk);
      #1;
      chk({tag, "_valid_count"}, 32'(valid_cnt - w), 32'd1);
      chk({tag, "_busy_after"}, 32'(busy), 32'd0);
      chk({tag, "_n_starts"}, 32'(dvd_q.size()), (v.m00 != 0) ? 32'd2 : 32'd0);
      if (v.m00 != 0 && dvd_q.size() == 2) begin
         chk({tag, "_dividend_x"}, dvd_q[0], {2'b00, v.m10});
         chk({tag, "_dividend_y"}, dvd_q[1], {2'b00, v.m01});
         chk({tag, "_divisor_x"}, 32'(dvs_q[0]), 32'(v.m00));
         chk({tag, "_divisor_y"}, 32'(dvs_q[1]), 32'(v.m00));
      end
   endtask

   initial begin
      int t, w, s, idle_cyc;
      vec_t v;
      tbl[0] = '{30'd10,   30'd6,    20'd4,  1'b0, 32'd0,   32'd0,  11'd2,  11'd1,  1'b0, 72};
      tbl[1] = '{30'd0,    30'd0,    20'd0,  1'b0, 32'd0,   32'd0,  11'd2,  11'd1,  1'b1, 1};
      tbl[2] = '{30'd1000, 30'd100,  20'd5,  1'b1, 32'd200, 32'd50, 11'd63, 11'd50, 1'b0, 72};
      tbl[3] = '{30'd3000, 30'd2000, 20'd50, 1'b0, 32'd0,   32'd0,  11'd60, 11'd40, 1'b0, 72};
      tbl[4] = '{30'd5000, 30'd10,   20'd10, 1'b0, 32'd0,   32'd0,  11'd63, 11'd1,  1'b0, 72};
      tbl[5] = '{30'd1000, 30'd2000, 20'd1,  1'b0, 32'd0,   32'd0,  11'd63, 11'd63, 1'b0, 72};
      tbl[6] = '{30'd7,    30'd9,    20'd0,  1'b0, 32'd0,   32'd0,  11'd63, 11'd63, 1'b1, 1};
      tbl[7] = '{30'd620,  30'd0,    20'd10, 1'b0, 32'd0,   32'd0,  11'd62, 11'd0,  1'b0, 72};

      rst = 1'b1; eof = 1'b0; m10 = '0; m01 = '0; m00 = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("reset_x", 32'(x), 32'd0);
      chk("reset_y", 32'(y), 32'd0);
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_no_obj", 32'(no_obj), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_flags", {30'd0, overrun, timeout_err}, 32'd0);
      chk("reset_div", {div_dividend[30:0], div_start}, 32'd0);

      for (int i = 0; i < 8; i++) run_frame(tbl[i], $sformatf("vec%0d", i));
      chk("no_overrun_yet", 32'(overrun), 32'd0);

      // Frames B, C, D arrive while A computes: A then D published
      sb_q.push_back('{11'd5, 11'd3, 1'b0});
      sb_q.push_back('{11'd10, 11'd5, 1'b0});
      w = valid_cnt;
      drive_eof(30'd20, 30'd12, 20'd4, t);
      repeat (8) @(negedge clk);
      drive_eof(30'd100, 30'd100, 20'd1, t);
      repeat (8) @(negedge clk);
      drive_eof(30'd300, 30'd300, 20'd3, t);
      repeat (8) @(negedge clk);
      drive_eof(30'd90, 30'd45, 20'd9, t);
      wait_valids(w + 2, 400);
      repeat (5) @(negedge clk);
      #1;
      chk("ovr_valid_count", 32'(valid_cnt - w), 32'd2);
      chk("ovr_overrun", 32'(overrun), 32'd1);
      chk("ovr_timeout_err", 32'(timeout_err), 32'd0);
      chk("ovr_busy", 32'(busy), 32'd0);

      // Divider never answers
      div_en = 1'b0;
      dvd_q.delete();
      w = valid_cnt;
      drive_eof(30'd8, 30'd8, 20'd2, t);
      for (int k = 0; k < 20 && dvd_q.size() == 0; k++) @(negedge clk);
      s = last_start_cyc;
      idle_cyc = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         #1;
         if (!busy) begin
            idle_cyc = cyc;
            break;
         end
      end
      chk("tmo_idle_after_wait_x", 32'(idle_cyc - s - 1), 32'd64);
      chk("tmo_timeout_err", 32'(timeout_err), 32'd1);
      chk("tmo_overrun", 32'(overrun), 32'd1);
      chk("tmo_no_valid", 32'(valid_cnt - w), 32'd0);
      div_en = 1'b1;
      v = '{30'd12, 30'd18, 20'd6, 1'b0, 32'd0, 32'd0, 11'd2, 11'd3, 1'b0, 72};
      run_frame(v, "post_tmo");

      // Reset during WAIT_Y; the model's later div_qv is stray
      dvd_q.delete();
      w = valid_cnt;
      drive_eof(30'd40, 30'd40, 20'd4, t);
      for (int k = 0; k < 100 && dvd_q.size() < 2; k++) @(negedge clk);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_x", 32'(x), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_flags", {28'd0, no_obj, overrun, timeout_err, busy}, 32'd0);
      chk("rst_div_out", {div_dividend[30:0], div_start}, 32'd0);
      chk("rst_divisor", 32'(div_divisor), 32'd0);
      repeat (60) @(negedge clk);
      #1;
      chk("rst_no_valid", 32'(valid_cnt - w), 32'd0);
      chk("rst_busy_after_stray", 32'(busy), 32'd0);
      chk("rst_x_after_stray", 32'(x), 32'd0);

      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      chk("no_back_to_back_start", 32'(consec_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
